// File: rtl/tag_ctrl_pkg.sv
// tag_ctrl_pkg -- shared widths, entry field layout and FSM state encoding
// for the 4-way tag controller.
//   Entry layout (ENTRY_W bits): [VALID_BIT] = valid, [TAG_W-1:0] = tag.
//   Tag RAM write address is {index, way}, so the INIT sweep counter is
//   IDX_W+WAY_W bits wide and covers every entry exactly once.
package tag_ctrl_pkg;

  localparam int TAG_W     = 17;
  localparam int IDX_W     = 8;
  localparam int WAYS      = 4;
  localparam int WAY_W     = 2;
  localparam int ENTRY_W   = TAG_W + 1;
  localparam int VALID_BIT = TAG_W;
  localparam int NUM_SETS  = 1 << IDX_W;
  localparam int SWEEP_W   = IDX_W + WAY_W;

  localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_WR
  } state_t;

  function automatic logic entry_valid(input logic [ENTRY_W-1:0] e);
    return e[VALID_BIT];
  endfunction

  function automatic logic [TAG_W-1:0] entry_tag(input logic [ENTRY_W-1:0] e);
    return e[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/tag_ctrl_if.sv
// tag_ctrl_if -- lookup request/response and fill handshake bundle.
//   req_*  : lookup request (valid/ready), set index and compare tag
//   resp_* : one-cycle lookup result pulse, hit flag and hit/victim way
//   fill_* : tag write request (valid/ready), index, way, tag, invalidate
//   master : requester side (drives req_*/fill_*), slave : tag_ctrl side
interface tag_ctrl_if;
  import tag_ctrl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;

  logic             fill_valid;
  logic             fill_ready;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_inval;

  modport master (
    output req_valid, req_index, req_tag,
    output fill_valid, fill_index, fill_way, fill_tag, fill_inval,
    input  req_ready, resp_valid, resp_hit, resp_way, fill_ready
  );

  modport slave (
    input  req_valid, req_index, req_tag,
    input  fill_valid, fill_index, fill_way, fill_tag, fill_inval,
    output req_ready, resp_valid, resp_hit, resp_way, fill_ready
  );

endinterface

// File: rtl/tag_victim_sel.sv
// tag_victim_sel -- combinational miss-way picker.
//   valid : per-way valid bits of the looked-up set
//   rr    : round-robin pointer of that set
//   way   : lowest invalid way, or rr when every way is valid
module tag_victim_sel
  import tag_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr,
  output logic [WAY_W-1:0] way
);

  // Scanning downward lets the lowest invalid way overwrite any higher one.
  always_comb begin
    way = rr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) way = w[WAY_W-1:0];
    end
  end

endmodule

// File: rtl/tag_ctrl.sv
// tag_ctrl -- 4-way set-associative tag lookup / fill controller driving an
// external tag block RAM.
//   clk, rst    : sole clock, synchronous active-high reset
//   bus         : tag_ctrl_if.slave (lookup request/response, fill request)
//   tr_r_index  : RAM read set index (all 4 ways read in parallel)
//   tr_tag_out  : RAM read data, way n at [18n+17:18n], valid in S_CMP
//   tr_w_index  : RAM write address {index, way}
//   tr_tag_in   : RAM write data {valid, tag}
//   tr_wr_en    : RAM write enable (INIT sweep and fills only)
//   busy        : high while the INIT sweep clears the RAM
//
// state   | meaning
// S_INIT  | clearing every RAM entry, one per cycle
// S_IDLE  | accepting fill (priority) or lookup
// S_ISSUE | read address presented to RAM
// S_WAIT  | RAM read in flight
// S_CMP   | read data valid; compare and register response
// S_WR    | single-cycle fill write
module tag_ctrl
  import tag_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  tag_ctrl_if.slave                bus,
  output logic [IDX_W-1:0]         tr_r_index,
  input  logic [WAYS*ENTRY_W-1:0]  tr_tag_out,
  output logic [SWEEP_W-1:0]       tr_w_index,
  output logic [ENTRY_W-1:0]       tr_tag_in,
  output logic                     tr_wr_en,
  output logic                     busy
);

  state_t             state;
  logic [SWEEP_W-1:0] sweep_cnt;

  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   tag_q;

  logic [IDX_W-1:0]   f_idx_q;
  logic [WAY_W-1:0]   f_way_q;
  logic [TAG_W-1:0]   f_tag_q;
  logic               f_inval_q;

  logic [WAY_W-1:0]   rr [NUM_SETS];

  logic               resp_valid_q;
  logic               resp_hit_q;
  logic [WAY_W-1:0]   resp_way_q;

  logic [WAYS-1:0]    valid_vec;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim_way;

  // Fill has priority over lookup when both are offered in IDLE.
  assign bus.fill_ready = (state == S_IDLE);
  assign bus.req_ready  = (state == S_IDLE) && !bus.fill_valid;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = resp_way_q;

  assign busy       = (state == S_INIT);
  assign tr_r_index = idx_q;
  // Gated by rst so no write is issued in a reset cycle, even if the FSM is
  // already sitting in S_INIT.
  assign tr_wr_en   = !rst && ((state == S_INIT) || (state == S_WR));

  always_comb begin
    if (state == S_WR) begin
      tr_w_index = {f_idx_q, f_way_q};
      tr_tag_in  = {!f_inval_q, f_inval_q ? {TAG_W{1'b0}} : f_tag_q};
    end else begin
      tr_w_index = sweep_cnt;
      tr_tag_in  = '0;
    end
  end

  // Downward scan so the lowest matching way wins on multiple hits.
  always_comb begin
    valid_vec = '0;
    hit       = 1'b0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      valid_vec[w] = entry_valid(tr_tag_out[w*ENTRY_W +: ENTRY_W]);
      if (entry_valid(tr_tag_out[w*ENTRY_W +: ENTRY_W]) &&
          entry_tag(tr_tag_out[w*ENTRY_W +: ENTRY_W]) == tag_q) begin
        hit     = 1'b1;
        hit_way = w[WAY_W-1:0];
      end
    end
  end

  tag_victim_sel u_victim (
    .valid (valid_vec),
    .rr    (rr[idx_q]),
    .way   (victim_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      sweep_cnt    <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      for (int i = 0; i < NUM_SETS; i++) rr[i] <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == SWEEP_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.fill_valid) begin
            f_idx_q   <= bus.fill_index;
            f_way_q   <= bus.fill_way;
            f_tag_q   <= bus.fill_tag;
            f_inval_q <= bus.fill_inval;
            state     <= S_WR;
          end else if (bus.req_valid) begin
            idx_q <= bus.req_index;
            tag_q <= bus.req_tag;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_CMP;
        S_CMP: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit;
          resp_way_q   <= hit ? hit_way : victim_way;
          state        <= S_IDLE;
        end
        S_WR: begin
          // Next victim is the way after the one just filled; 2-bit add wraps.
          if (!f_inval_q) rr[f_idx_q] <= f_way_q + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl -- directed self-checking bench for tag_ctrl with a behavioural
// tag RAM (registered read of all 4 ways, write on clock edge).
module tb_tag_ctrl;
  import tag_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;
  always #5 clk = ~clk;

  tag_ctrl_if bus ();

  logic [7:0]  tr_r_index;
  logic [71:0] tr_tag_out;
  logic [9:0]  tr_w_index;
  logic [17:0] tr_tag_in;
  logic        tr_wr_en;
  logic        busy;

  tag_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tr_r_index (tr_r_index),
    .tr_tag_out (tr_tag_out),
    .tr_w_index (tr_w_index),
    .tr_tag_in  (tr_tag_in),
    .tr_wr_en   (tr_wr_en),
    .busy       (busy)
  );

  // Tag RAM; preload fills it with valid garbage so the INIT sweep matters.
  logic [17:0] mem [1024];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 18'h3FFFF;
    end else if (tr_wr_en) begin
      mem[tr_w_index] <= tr_tag_in;
    end
    for (int n = 0; n < 4; n++) tr_tag_out[n*18 +: 18] <= mem[{tr_r_index, n[1:0]}];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_init(output int cyc, output int errs, output int resps);
    cyc = 0; errs = 0; resps = 0;
    #1;
    while (busy && cyc < 2000) begin
      if (!tr_wr_en || tr_w_index != cyc[9:0] || tr_tag_in != 18'h0) errs++;
      if (bus.resp_valid) resps++;
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic lookup(input logic [7:0] idx, input logic [16:0] tag,
                        output logic hit, output logic [1:0] way,
                        output int lat, output logic rdy);
    int guard = 0;
    bus.req_valid = 1'b1; bus.req_index = idx; bus.req_tag = tag;
    #1;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
    end while (!bus.resp_valid && lat < 10);
    hit = bus.resp_hit;
    way = bus.resp_way;
    rdy = bus.req_ready;
  endtask

  task automatic exp_lookup(input string name, input logic [7:0] idx, input logic [16:0] tag,
                            input logic exp_hit, input logic [1:0] exp_way);
    logic h; logic [1:0] w; int lat; logic rdy;
    lookup(idx, tag, h, w, lat, rdy);
    check({name, "_lat"}, 32'(lat), 3);
    check({name, "_hit"}, 32'(h), 32'(exp_hit));
    check({name, "_way"}, 32'(w), 32'(exp_way));
    check({name, "_rdy_at_resp"}, 32'(rdy), 1);
  endtask

  task automatic fill(input logic [7:0] idx, input logic [1:0] way, input logic [16:0] tag,
                      input logic inval, input logic [17:0] exp_data);
    int guard = 0;
    bus.fill_valid = 1'b1; bus.fill_index = idx; bus.fill_way = way;
    bus.fill_tag = tag; bus.fill_inval = inval;
    #1;
    while (!bus.fill_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.fill_valid = 1'b0;
    #1;
    check("fill_wr_en", 32'(tr_wr_en), 1);
    check("fill_widx", 32'(tr_w_index), 32'({idx, way}));
    check("fill_data", 32'(tr_tag_in), 32'(exp_data));
    @(negedge clk); #1;
  endtask

  int cyc, errs, resps;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_index = 0; bus.req_tag = 0;
    bus.fill_valid = 0; bus.fill_index = 0; bus.fill_way = 0;
    bus.fill_tag = 0; bus.fill_inval = 0;

    preload = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 1);
    check("rst_wr_en", 32'(tr_wr_en), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_fill_ready", 32'(bus.fill_ready), 0);

    @(negedge clk);
    rst = 1'b0;
    run_init(cyc, errs, resps);
    check("init_cycles", 32'(cyc), 1024);
    check("init_seq_errs", 32'(errs), 0);
    check("post_init_req_ready", 32'(bus.req_ready), 1);
    check("post_init_wr_en", 32'(tr_wr_en), 0);

    // First lookup: RAM cleared, so miss on way 0.
    exp_lookup("miss_idx5", 8'h05, 17'h1ABCD, 1'b0, 2'd0);
    @(negedge clk); #1;
    check("resp_pulse_1cyc", 32'(bus.resp_valid), 0);

    fill(8'h05, 2'd2, 17'h1ABCD, 1'b0, 18'h3ABCD);
    exp_lookup("hit_idx5", 8'h05, 17'h1ABCD, 1'b1, 2'd2);

    // Set 7: fill 0..3 leaves rr wrapped to 0.
    fill(8'h07, 2'd0, 17'h00100, 1'b0, 18'h20100);
    fill(8'h07, 2'd1, 17'h00101, 1'b0, 18'h20101);
    fill(8'h07, 2'd2, 17'h00102, 1'b0, 18'h20102);
    fill(8'h07, 2'd3, 17'h00103, 1'b0, 18'h20103);
    exp_lookup("idx7_rr_wrap", 8'h07, 17'h00200, 1'b0, 2'd0);
    exp_lookup("idx7_hit2", 8'h07, 17'h00102, 1'b1, 2'd2);
    fill(8'h07, 2'd1, 17'h1FFFF, 1'b1, 18'h00000);
    exp_lookup("idx7_inval1", 8'h07, 17'h00200, 1'b0, 2'd1);

    // Set 9: reverse-order fills leave rr = 1; hits and inval leave it alone.
    fill(8'h09, 2'd3, 17'h00903, 1'b0, 18'h20903);
    fill(8'h09, 2'd2, 17'h00902, 1'b0, 18'h20902);
    fill(8'h09, 2'd1, 17'h00901, 1'b0, 18'h20901);
    fill(8'h09, 2'd0, 17'h00900, 1'b0, 18'h20900);
    exp_lookup("idx9_rr1", 8'h09, 17'h00AAA, 1'b0, 2'd1);
    exp_lookup("idx9_hit3", 8'h09, 17'h00903, 1'b1, 2'd3);
    exp_lookup("idx9_rr_after_hit", 8'h09, 17'h00AAA, 1'b0, 2'd1);
    fill(8'h09, 2'd3, 17'h00903, 1'b1, 18'h00000);
    exp_lookup("idx9_inval3", 8'h09, 17'h00AAA, 1'b0, 2'd3);
    fill(8'h09, 2'd3, 17'h009F3, 1'b0, 18'h209F3);
    exp_lookup("idx9_rr_wrap", 8'h09, 17'h00AAA, 1'b0, 2'd0);

    // Duplicate tag in ways 1 and 3: lowest way wins.
    fill(8'h0A, 2'd1, 17'h0AAAA, 1'b0, 18'h2AAAA);
    fill(8'h0A, 2'd3, 17'h0AAAA, 1'b0, 18'h2AAAA);
    exp_lookup("idx10_multi_hit", 8'h0A, 17'h0AAAA, 1'b1, 2'd1);

    // Fill and lookup offered together: fill wins, lookup served afterwards.
    bus.fill_valid = 1'b1; bus.fill_index = 8'h0B; bus.fill_way = 2'd0;
    bus.fill_tag = 17'h12345; bus.fill_inval = 1'b0;
    bus.req_valid = 1'b1; bus.req_index = 8'h0B; bus.req_tag = 17'h12345;
    #1;
    check("both_fill_ready", 32'(bus.fill_ready), 1);
    check("both_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.fill_valid = 1'b0;
    #1;
    check("both_wr_req_ready", 32'(bus.req_ready), 0);
    check("both_wr_en", 32'(tr_wr_en), 1);
    @(negedge clk); #1;
    exp_lookup("both_lookup", 8'h0B, 17'h12345, 1'b1, 2'd0);

    // Reset while a lookup sits in WAIT.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_index = 8'h05; bus.req_tag = 17'h1ABCD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("wait_rst_busy", 32'(busy), 1);
    check("wait_rst_resp_valid", 32'(bus.resp_valid), 0);
    check("wait_rst_wr_en", 32'(tr_wr_en), 0);
    rst = 1'b0;
    run_init(cyc, errs, resps);
    check("reinit_cycles", 32'(cyc), 1024);
    check("reinit_seq_errs", 32'(errs), 0);
    check("reinit_no_resp", 32'(resps), 0);
    exp_lookup("post_rst_idx5", 8'h05, 17'h1ABCD, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
